// File: rtl/bist_lfsr_controller.sv
// Logic BIST engine for a scan-inserted core. An LFSR drives the scan-chain
// inputs and a MISR compacts the scan outputs. A state machine sequences
// shift and capture for NPATTERNS patterns, then the final signature is
// compared with a golden value. With bist_en low the block is a
// transparent bypass from the ATE scan pins to the core.
// Ports: CK, reset_n (sync, active low), bist_en, start, seed, golden,
//   scan_en_ext, si_ext, so -> chain_si, scan_en, busy, done, pass,
//   signature, pattern_cnt.
// Optional macro BIST_XMASK_EN adds input xmask. It is captured on start
// and masks X-prone chains out of the MISR input.
module bist_lfsr_controller #(
    parameter int                  NCHAINS   = 7,
    parameter int                  LFSR_W    = 7,
    parameter logic [LFSR_W-1:0]   LFSR_TAPS = 7'h60,
    parameter logic [NCHAINS-1:0]  MISR_TAPS = 7'h60,
    parameter int                  CHAIN_LEN = 33,
    parameter int                  NPATTERNS = 1024,
    parameter int                  CNT_W     = 16
) (
    input  logic               CK,
    input  logic               reset_n,
    input  logic               bist_en,
    input  logic               start,
    input  logic [LFSR_W-1:0]  seed,
    input  logic [NCHAINS-1:0] golden,
    input  logic               scan_en_ext,
    input  logic [NCHAINS-1:0] si_ext,
    input  logic [NCHAINS-1:0] so,
`ifdef BIST_XMASK_EN
    input  logic [NCHAINS-1:0] xmask,
`endif
    output logic [NCHAINS-1:0] chain_si,
    output logic               scan_en,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NCHAINS-1:0] signature,
    output logic [CNT_W-1:0]   pattern_cnt
);

    localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] NPAT    = CNT_W'(NPATTERNS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [NCHAINS-1:0]  misr_q, misr_d;
    logic [SC_W-1:0]     shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0]    pattern_cnt_q, pattern_cnt_d;

    logic                accept;
    logic                last_shift;
    logic [CNT_W-1:0]    cnt_inc;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [NCHAINS-1:0]  misr_in;
    logic [NCHAINS-1:0]  misr_step;
    logic                fsm_scan_en;

`ifdef BIST_XMASK_EN
    logic [NCHAINS-1:0]  xmask_q, xmask_d;
    assign misr_in = so & ~xmask_q;
`else
    assign misr_in = so;
`endif

    assign accept     = bist_en && start &&
                        (state_q == S_IDLE || state_q == S_DONE);
    assign last_shift = (shift_cnt_q == SC_LAST);
    assign cnt_inc    = (pattern_cnt_q == CNT_MAX) ? pattern_cnt_q
                                                   : pattern_cnt_q + 1'b1;
    assign lfsr_step  = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign misr_step  = {misr_q[NCHAINS-2:0], ^(misr_q & MISR_TAPS)}
                        ^ misr_in;

    // State register
    always_ff @(posedge CK) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge CK) begin
        if (!reset_n) begin
            lfsr_q        <= LFSR_W'(1);
            misr_q        <= '0;
            shift_cnt_q   <= '0;
            pattern_cnt_q <= '0;
`ifdef BIST_XMASK_EN
            xmask_q       <= '0;
`endif
        end else begin
            lfsr_q        <= lfsr_d;
            misr_q        <= misr_d;
            shift_cnt_q   <= shift_cnt_d;
            pattern_cnt_q <= pattern_cnt_d;
`ifdef BIST_XMASK_EN
            xmask_q       <= xmask_d;
`endif
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (!bist_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_SHIFT;
                S_SHIFT:        if (last_shift) state_d = S_CAPTURE;
                S_CAPTURE:      state_d = (cnt_inc == NPAT) ? S_UNLOAD
                                                            : S_SHIFT;
                S_UNLOAD:       if (last_shift) state_d = S_DONE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values; everything holds unless the FSM advances it
    always_comb begin
        lfsr_d        = lfsr_q;
        misr_d        = misr_q;
        shift_cnt_d   = shift_cnt_q;
        pattern_cnt_d = pattern_cnt_q;
`ifdef BIST_XMASK_EN
        xmask_d       = xmask_q;
`endif
        if (accept) begin
            // An all-zero seed would lock the LFSR up
            lfsr_d        = (seed == '0) ? LFSR_W'(1) : seed;
            misr_d        = '0;
            shift_cnt_d   = '0;
            pattern_cnt_d = '0;
`ifdef BIST_XMASK_EN
            xmask_d       = xmask;
`endif
        end else if (bist_en) begin
            case (state_q)
                S_SHIFT: begin
                    lfsr_d = lfsr_step;
                    // First unload holds uninitialised core state
                    if (pattern_cnt_q != '0) misr_d = misr_step;
                    shift_cnt_d = last_shift ? '0 : shift_cnt_q + 1'b1;
                end
                S_CAPTURE: begin
                    pattern_cnt_d = cnt_inc;
                end
                S_UNLOAD: begin
                    lfsr_d      = lfsr_step;
                    misr_d      = misr_step;
                    shift_cnt_d = last_shift ? '0 : shift_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy        = (state_q == S_SHIFT) || (state_q == S_CAPTURE) ||
                      (state_q == S_UNLOAD);
        fsm_scan_en = (state_q == S_SHIFT) || (state_q == S_UNLOAD);
        done        = (state_q == S_DONE);
        pass        = (state_q == S_DONE) && (misr_q == golden);
        chain_si    = bist_en ? lfsr_q[NCHAINS-1:0] : si_ext;
        scan_en     = bist_en ? fsm_scan_en : scan_en_ext;
        signature   = misr_q;
        pattern_cnt = pattern_cnt_q;
    end

endmodule

// File: tb/tb_bist_lfsr_controller.sv
// Self-checking bench for bist_lfsr_controller (small run: 4 patterns x 8).
// Phase-arithmetic reference model plus hand-computed literal checks.
module tb_bist_lfsr_controller;

    localparam int NC = 7;
    localparam int LW = 7;
    localparam int NP = 4;
    localparam int CL = 8;
    localparam int CW = 16;
    localparam int RUN_T = NP * (CL + 1) + CL;

    logic          CK = 1'b0;
    logic          reset_n = 1'b0;
    logic          bist_en = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] seed = '0;
    logic [NC-1:0] golden = '0;
    logic          scan_en_ext = 1'b0;
    logic [NC-1:0] si_ext = '0;
    logic [NC-1:0] so = '0;
`ifdef BIST_XMASK_EN
    logic [NC-1:0] xmask = '0;
`endif
    logic [NC-1:0] chain_si;
    logic          scan_en;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NC-1:0] signature;
    logic [CW-1:0] pattern_cnt;

    bist_lfsr_controller #(
        .NCHAINS(NC), .LFSR_W(LW), .LFSR_TAPS(7'h60), .MISR_TAPS(7'h60),
        .CHAIN_LEN(CL), .NPATTERNS(NP), .CNT_W(CW)
    ) dut (
        .CK(CK), .reset_n(reset_n), .bist_en(bist_en), .start(start),
        .seed(seed), .golden(golden), .scan_en_ext(scan_en_ext),
        .si_ext(si_ext), .so(so),
`ifdef BIST_XMASK_EN
        .xmask(xmask),
`endif
        .chain_si(chain_si), .scan_en(scan_en), .busy(busy), .done(done),
        .pass(pass), .signature(signature), .pattern_cnt(pattern_cnt)
    );

    always #5 CK = ~CK;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    bit chk_en = 0;
    bit so_rand = 0;

    always @(posedge CK) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     nm, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
        if (so_rand) so = NC'($urandom);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [LW-1:0] f_lfsr(input logic [LW-1:0] x);
        return {x[LW-2:0], ^(x & 7'h60)};
    endfunction

    function automatic logic [NC-1:0] f_misr(input logic [NC-1:0] m,
                                             input logic [NC-1:0] d);
        return {m[NC-2:0], ^(m & 7'h60)} ^ d;
    endfunction

    // Within a run, cycle t is a shift cycle unless it is the capture slot
    // that ends each pattern; everything after the last capture is unload.
    function automatic bit f_shifting(input int t);
        if (t < NP * (CL + 1)) return (t % (CL + 1)) != CL;
        return 1'b1;
    endfunction

    int            m_mode = 0;   // 0 idle, 1 running, 2 done
    int            m_t = 0;
    logic [LW-1:0] m_lfsr = 1;
    logic [NC-1:0] m_misr = 0;
    int            m_pc = 0;

    always @(posedge CK) begin
        logic [NC-1:0] din;
`ifdef BIST_XMASK_EN
        din = so & ~m_xmask;
`else
        din = so;
`endif
        if (!reset_n) begin
            m_mode <= 0; m_t <= 0; m_lfsr <= 1; m_misr <= 0; m_pc <= 0;
        end else if (!bist_en) begin
            m_mode <= 0;
        end else if (m_mode != 1 && start) begin
            m_mode <= 1; m_t <= 0; m_misr <= 0; m_pc <= 0;
            m_lfsr <= (seed == 0) ? LW'(1) : seed;
`ifdef BIST_XMASK_EN
            m_xmask <= xmask;
`endif
        end else if (m_mode == 1) begin
            if (f_shifting(m_t)) begin
                m_lfsr <= f_lfsr(m_lfsr);
                if (m_t / (CL + 1) > 0) m_misr <= f_misr(m_misr, din);
            end else begin
                m_pc <= m_pc + 1;
            end
            m_t <= m_t + 1;
            if (m_t + 1 == RUN_T) m_mode <= 2;
        end
    end
`ifdef BIST_XMASK_EN
    logic [NC-1:0] m_xmask = 0;
`endif

    // Every-cycle comparison against the model
    always @(negedge CK) begin
        if (chk_en) begin
            bit run;
            run = (m_mode == 1);
            chk("chain_si", chain_si, bist_en ? m_lfsr : si_ext);
            chk("scan_en", scan_en,
                bist_en ? (run && f_shifting(m_t)) : scan_en_ext);
            chk("busy", busy, run);
            chk("done", done, m_mode == 2);
            chk("pass", pass, (m_mode == 2) && (m_misr == golden));
            chk("signature", signature, m_misr);
            chk("pattern_cnt", pattern_cnt, m_pc);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [NC-1:0] exp_seq [7] = '{7'h01, 7'h02, 7'h04, 7'h08,
                                   7'h10, 7'h20, 7'h41};

    task automatic pulse_start(input logic [LW-1:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int e);
        int g;
        g = 0;
        while (!done && g < 200) begin
            tick();
            g++;
        end
        if (!done) chk("done_timeout", 0, 1);
        e = edge_n;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_pass"}, pass, 0);
        chk({nm, "_sig"}, signature, 0);
        chk({nm, "_pcnt"}, pattern_cnt, 0);
    endtask

    initial begin
        int k, a, e, g;
        int lows[$];
        logic [LW-1:0] x;

        // Model sanity: maximal-length TPG polynomial
        x = 1;
        g = 0;
        for (int i = 1; i <= 200; i++) begin
            x = f_lfsr(x);
            if (x == 1 && g == 0) g = i;
        end
        chk("lfsr_period", g, 127);

        // Reset
        reset_n = 1'b0;
        tick();
        tick();
        chk_en = 1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        tick();

        // Run A: seed 1, random scan-out data, timing checks
        so_rand = 1;
        golden  = 7'h2a;
        k = edge_n;
        pulse_start(7'h01);
        for (int i = 0; i < 7; i++) begin
            chk("seq_seed1", chain_si, exp_seq[i]);
            tick();
        end
        g = 0;
        while (!done && g < 200) begin
            if (busy && !scan_en) lows.push_back(edge_n + 1);
            tick();
            g++;
        end
        chk("runA_done", done, 1);
        chk("runA_done_edge", edge_n - k, 45);
        chk("runA_ncapture", lows.size(), 4);
        for (int i = 0; i < lows.size() && i < 4; i++)
            chk("runA_capture_edge", lows[i] - k, 10 + 9 * i);
        chk("runA_pcnt", pattern_cnt, 4);

        // Run B: seed 0 behaves as seed 1; all-zero scan-out
        so_rand = 0;
        so      = '0;
        golden  = '0;
        pulse_start(7'h00);
        for (int i = 0; i < 7; i++) begin
            chk("seq_seed0", chain_si, exp_seq[i]);
            tick();
        end
        wait_done(e);
        chk("runB_sig", signature, 0);
        chk("runB_pass_g0", pass, 1);
        golden = 7'h01;
        #1;
        chk("runB_pass_g1", pass, 0);

        // Run C: bypass taken mid-shift, then a clean run
        so_rand = 1;
        pulse_start(7'h05);
        tick();
        tick();
        bist_en     = 1'b0;
        si_ext      = 7'h55;
        scan_en_ext = 1'b1;
        #1;
        chk("bypass_si", chain_si, 7'h55);
        chk("bypass_se", scan_en, 1);
        tick();
        chk("bypass_busy", busy, 0);
        scan_en_ext = 1'b0;
        si_ext      = 7'h2c;
        bist_en     = 1'b1;
        tick();
        pulse_start(7'h11);
        wait_done(e);
        chk("runC_done", done, 1);
        chk("runC_pcnt", pattern_cnt, 4);

        // Run D: reset during unload, then restart immediately
        pulse_start(7'h33);
        a = edge_n;
        while (edge_n < a + NP * (CL + 1) + 2) tick();
        chk("runD_unload_se", scan_en, 1);
        reset_n = 1'b0;
        tick();
        chk_reset_vals("midreset");
        chk("midreset_si", chain_si, 7'h01);
        reset_n = 1'b1;
        pulse_start(7'h09);
        chk("restart_busy", busy, 1);
        wait_done(e);
        chk("runD_done", done, 1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
